// File: rtl/modulo_debounce_botoes.sv
// Four-channel pushbutton debouncer: 2-FF synchronizer feeding one 4-state FSM per key.
// Define DEBOUNCE_AUTOREPEAT_EN to re-pulse a held key every REPEAT_CYCLES cycles.
module modulo_debounce_botoes #(
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_WIDTH     = 19,
    parameter int REPEAT_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       Nclr,
    input  logic [3:0] Nbotao,
    output logic [3:0] nivel,
    output logic [3:0] pulso
);

    // Bit 1 of the encoding is the debounced level, so nivel decodes without glitches.
    typedef enum logic [1:0] {
        SOLTO       = 2'b00,
        PEND_PRESS  = 2'b01,
        PRESSIONADO = 2'b11,
        PEND_SOLTO  = 2'b10
    } estado_t;

    // The sample that leaves a stable state is the first of the STABLE_CYCLES hold
    // samples, so the pending state accepts once STABLE_CYCLES-1 more have been seen.
    localparam int                   LAST_INT = (STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LAST_INT);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam int                   REP_WIDTH = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [REP_WIDTH-1:0] REP_LAST  = REP_WIDTH'(REPEAT_CYCLES - 1);
`else
    logic unused_repeat;
    assign unused_repeat = ^REPEAT_CYCLES;
`endif

    logic [3:0] sync1;
    logic [3:0] s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge Nclr) begin
        if (!Nclr) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= ~Nbotao;
            s     <= sync1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_canal
        estado_t              estado, estado_prox;
        logic [CNT_WIDTH-1:0] cnt, cnt_prox;
        logic                 pulso_q, pulso_prox;
`ifdef DEBOUNCE_AUTOREPEAT_EN
        logic [REP_WIDTH-1:0] rep, rep_prox;
`endif

        always_ff @(posedge clk or negedge Nclr) begin
            if (!Nclr) begin
                estado  <= SOLTO;
                cnt     <= '0;
                pulso_q <= 1'b0;
            end else begin
                estado  <= estado_prox;
                cnt     <= cnt_prox;
                pulso_q <= pulso_prox;
            end
        end

`ifdef DEBOUNCE_AUTOREPEAT_EN
        always_ff @(posedge clk or negedge Nclr) begin
            if (!Nclr) rep <= '0;
            else       rep <= rep_prox;
        end
`endif

        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        // A zero default for the counters also clears them on every state change.
        always_comb begin
            estado_prox = estado;
            cnt_prox    = '0;
            pulso_prox  = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_prox    = '0;
`endif
            unique case (estado)
                SOLTO: begin
                    if (s[i]) estado_prox = PEND_PRESS;
                end
                PEND_PRESS: begin
                    if (!s[i]) begin
                        estado_prox = SOLTO;
                    end else if (cnt >= CNT_LAST) begin
                        estado_prox = PRESSIONADO;
                        pulso_prox  = 1'b1;
                    end else begin
                        cnt_prox = (cnt == '1) ? cnt : cnt + 1'b1;
                    end
                end
                PRESSIONADO: begin
                    if (!s[i]) begin
                        estado_prox = PEND_SOLTO;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                    end else if (rep >= REP_LAST) begin
                        pulso_prox = 1'b1;
                    end else begin
                        rep_prox = rep + 1'b1;
`endif
                    end
                end
                PEND_SOLTO: begin
                    if (s[i]) begin
                        estado_prox = PRESSIONADO;
                    end else if (cnt >= CNT_LAST) begin
                        estado_prox = SOLTO;
                    end else begin
                        cnt_prox = (cnt == '1) ? cnt : cnt + 1'b1;
                    end
                end
                default: estado_prox = SOLTO;
            endcase
        end

        assign nivel[i] = estado[1];
        assign pulso[i] = pulso_q;
    end

endmodule

// File: tb/tb_modulo_debounce_botoes.sv
// Self-checking bench for modulo_debounce_botoes: directed scenarios plus random bouncing,
// compared against a run-length model of the debounce rules.
module tb_modulo_debounce_botoes;

    localparam int STABLE = 4;
    localparam int REPEAT = 8;

    logic       clk;
    logic       Nclr;
    logic [3:0] Nbotao;
    logic [3:0] nivel;
    logic [3:0] pulso;

    int compared   = 0;
    int mismatched = 0;

    // Model: raw samples delayed two edges, accepted level, run of differing samples,
    // and edges spent steadily pressed since the last pulse.
    logic [3:0] m_d1, m_d2, m_nivel, m_pulso;
    int         m_run[4];
    int         m_held[4];
    int         r_left[4];

    modulo_debounce_botoes #(
        .STABLE_CYCLES(STABLE),
        .CNT_WIDTH    (4),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk   (clk),
        .Nclr  (Nclr),
        .Nbotao(Nbotao),
        .nivel (nivel),
        .pulso (pulso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void model_reset();
        m_d1    = '0;
        m_d2    = '0;
        m_nivel = '0;
        m_pulso = '0;
        for (int i = 0; i < 4; i++) begin
            m_run[i]  = 0;
            m_held[i] = 0;
        end
    endfunction

    task automatic model_edge();
        if (!Nclr) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            logic sample;
            int   prior;
            sample     = m_d2[i];
            prior      = m_run[i];
            m_pulso[i] = 1'b0;
            if (sample != m_nivel[i]) begin
                m_run[i]  = prior + 1;
                m_held[i] = 0;
                if (m_run[i] == STABLE) begin
                    m_nivel[i] = sample;
                    m_run[i]   = 0;
                    m_pulso[i] = sample;
                end
            end else begin
                m_run[i] = 0;
                if (m_nivel[i] && prior == 0) begin
                    m_held[i]++;
                    if (m_held[i] == REPEAT) begin
                        m_held[i] = 0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                        m_pulso[i] = 1'b1;
`endif
                    end
                end else begin
                    m_held[i] = 0;
                end
            end
        end
        m_d2 = m_d1;
        m_d1 = ~Nbotao;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("model_nivel", nivel, m_nivel);
        check("model_pulso", pulso, m_pulso);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        logic rep_hit;

        // Reset held with every key pressed: synchronizers must stay cleared.
        Nclr   = 1'b0;
        Nbotao = 4'b0000;
        model_reset();
        #1;
        check("reset_nivel_t0", nivel, 4'b0000);
        check("reset_pulso_t0", pulso, 4'b0000);
        for (int e = 1; e <= 5; e++) begin
            tick();
            check("reset_nivel", nivel, 4'b0000);
            check("reset_pulso", pulso, 4'b0000);
        end
        Nbotao = 4'b1111;
        Nclr   = 1'b1;
        idle(8);

        // Clean press on channel 0, then clean release.
        Nbotao[0] = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("press_nivel", nivel, (e >= 6) ? 4'b0001 : 4'b0000);
            check("press_pulso", pulso, (e == 6) ? 4'b0001 : 4'b0000);
        end
        Nbotao[0] = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            check("release_nivel", nivel, (e >= 6) ? 4'b0000 : 4'b0001);
            check("release_pulso", pulso, 4'b0000);
        end

        // Bounce on channel 1: never held for STABLE cycles.
        Nbotao[1] = 1'b0;
        for (int e = 1; e <= 18; e++) begin
            if (e == 4) Nbotao[1] = 1'b1;
            if (e == 5) Nbotao[1] = 1'b0;
            if (e == 8) Nbotao[1] = 1'b1;
            tick();
            check("bounce_nivel", nivel, 4'b0000);
            check("bounce_pulso", pulso, 4'b0000);
        end

        // Simultaneous press on channels 3 and 1.
        Nbotao = 4'b0101;
        for (int e = 1; e <= 12; e++) begin
            tick();
            check("simul_nivel", nivel, (e >= 6) ? 4'b1010 : 4'b0000);
            check("simul_pulso", pulso, (e == 6) ? 4'b1010 : 4'b0000);
        end

        // Asynchronous clear mid-cycle while keys are accepted as pressed.
        @(negedge clk);
        #2;
        Nclr = 1'b0;
        model_reset();
        #1;
        check("async_nivel", nivel, 4'b0000);
        check("async_pulso", pulso, 4'b0000);
        tick();
        Nbotao = 4'b1111;
        Nclr   = 1'b1;
        idle(8);

        // Reset pulsed during a held press restarts the debounce from release.
        Nbotao[0] = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            check("midrst_pre_nivel", nivel, 4'b0000);
        end
        Nclr = 1'b0;
        model_reset();
        #1;
        check("midrst_clear_nivel", nivel, 4'b0000);
        check("midrst_clear_pulso", pulso, 4'b0000);
        tick();
        Nclr = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check("midrst_nivel", nivel, (e >= 6) ? 4'b0001 : 4'b0000);
            check("midrst_pulso", pulso, (e == 6) ? 4'b0001 : 4'b0000);
        end
        Nbotao = 4'b1111;
        idle(10);

        // Long hold on channel 2: repeat pulses only when auto-repeat is built in.
        Nbotao[2] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
`ifdef DEBOUNCE_AUTOREPEAT_EN
            rep_hit = (e >= 6) && ((e - 6) % REPEAT == 0);
`else
            rep_hit = (e == 6);
`endif
            tick();
            check("hold_nivel", nivel, (e >= 6) ? 4'b0100 : 4'b0000);
            check("hold_pulso", pulso, rep_hit ? 4'b0100 : 4'b0000);
        end
        Nbotao = 4'b1111;
        idle(10);

        // Random bouncing on all channels with one reset pulse in the middle.
        for (int i = 0; i < 4; i++) r_left[i] = int'($urandom_range(1, 9));
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 4; i++) begin
                r_left[i]--;
                if (r_left[i] == 0) begin
                    Nbotao[i] = ~Nbotao[i];
                    r_left[i] = int'($urandom_range(1, 9));
                end
            end
            if (c == 300) begin
                Nclr = 1'b0;
                model_reset();
            end
            if (c == 302) Nclr = 1'b1;
            tick();
        end
        Nbotao = 4'b1111;
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
